// File: rtl/quad_bingo_launch_pkg.sv
// rtl/quad_bingo_launch_pkg.sv - shared constants and types for the quad launch controller
//
// Purpose: register offsets, channel stride, channel state encoding, bit
// positions inside CTRL/STATUS/IRQ, default register-interface structs and a
// byte-strobe merge helper. Imported by the channel and the top module.
package quad_bingo_launch_pkg;

  // Address space layout
  localparam int unsigned ChStride   = 32'h20;
  localparam logic [4:0]  RegBaseLo  = 5'h00;
  localparam logic [4:0]  RegBaseHi  = 5'h04;
  localparam logic [4:0]  RegNumTask = 5'h08;
  localparam logic [4:0]  RegCtrl    = 5'h0C;
  localparam logic [4:0]  RegStatus  = 5'h10;
  localparam logic [4:0]  RegDoneCnt = 5'h14;
  localparam logic [4:0]  RegIrq     = 5'h18;
  localparam logic [4:0]  RegTimeout = 5'h1C;

  // Bit positions
  localparam int unsigned CtrlStartBit     = 0;
  localparam int unsigned CtrlAbortBit     = 1;
  localparam int unsigned StatusErrBit     = 2;
  localparam int unsigned StatusTimeoutBit = 3;
  localparam int unsigned IrqPendingBit    = 0;
  localparam int unsigned IrqEnableBit     = 1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StRun  = 2'd2
  } ch_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_struct_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_struct_t;

  // Merge write data into a 32-bit register, byte lane by byte lane.
  function automatic logic [31:0] apply_strb(input logic [31:0] cur,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  wstrb);
    logic [31:0] r;
    r = cur;
    for (int b = 0; b < 4; b++) begin
      if (wstrb[b]) r[8*b +: 8] = wdata[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/quad_bingo_launch_channel.sv
// rtl/quad_bingo_launch_channel.sv - one launch channel: registers, FSM, counters
//
// Purpose: holds a channel's BASE/NUM_TASK/IRQ/TIMEOUT registers, the
// IDLE->REQ->RUN launch FSM, launch snapshots, DONE_CNT and pending/enable.
// Optional feature macro: QUAD_LAUNCH_TIMEOUT_EN (run-time watchdog).
// Ports:
//   clk_i, rst_ni              clock, async active-low reset
//   sel_i/write_i/off_i/...    decoded register access for this channel
//   rdata_o, err_o             combinational read data / access error
//   launch_*                   valid/ready launch to the HW manager
//   done_i, abort_o            completion pulse in, abort pulse out
//   busy_o, irq_o              not-idle flag, pending & enable
module quad_bingo_launch_channel
  import quad_bingo_launch_pkg::*;
#(
  parameter int unsigned AddrWidth = 48
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 sel_i,
  input  logic                 write_i,
  input  logic [4:0]           off_i,
  input  logic [31:0]          wdata_i,
  input  logic [3:0]           wstrb_i,
  output logic [31:0]          rdata_o,
  output logic                 err_o,
  output logic                 launch_valid_o,
  input  logic                 launch_ready_i,
  output logic [AddrWidth-1:0] launch_base_addr_o,
  output logic [31:0]          launch_num_task_o,
  input  logic                 done_i,
  output logic                 abort_o,
  output logic                 busy_o,
  output logic                 irq_o
);

  localparam int unsigned HiW = AddrWidth - 32;

  ch_state_e            state_q, state_d;
  logic [AddrWidth-1:0] base_q, base_d;
  logic [31:0]          num_task_q, num_task_d;
  logic [AddrWidth-1:0] snap_base_q, snap_base_d;
  logic [31:0]          snap_num_q, snap_num_d;
  logic [31:0]          done_cnt_q, done_cnt_d;
  logic                 pending_q, pending_d;
  logic                 enable_q, enable_d;
  logic                 err_q, err_d;
  logic                 tmo_q, tmo_d;
  logic                 abort_q, abort_d;
`ifdef QUAD_LAUNCH_TIMEOUT_EN
  logic [31:0]          timeout_q, timeout_d;
  logic [31:0]          tcnt_q, tcnt_d;
`endif

  logic wr, idle, start_req, abort_req;

  assign wr   = sel_i & write_i;
  assign idle = (state_q == StIdle);
  // Both bits set counts as start only.
  assign start_req = wr && (off_i == RegCtrl) && wstrb_i[0] && wdata_i[CtrlStartBit];
  assign abort_req = wr && (off_i == RegCtrl) && wstrb_i[0] &&
                     wdata_i[CtrlAbortBit] && !wdata_i[CtrlStartBit];

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    num_task_d  = num_task_q;
    snap_base_d = snap_base_q;
    snap_num_d  = snap_num_q;
    done_cnt_d  = done_cnt_q;
    pending_d   = pending_q;
    enable_d    = enable_q;
    err_d       = err_q;
    tmo_d       = tmo_q;
    abort_d     = 1'b0;
    err_o       = 1'b0;
`ifdef QUAD_LAUNCH_TIMEOUT_EN
    timeout_d   = timeout_q;
    tcnt_d      = tcnt_q;
`endif

    // Software register writes; launch parameters are frozen while busy.
    if (wr) begin
      case (off_i)
        RegBaseLo: begin
          if (idle) base_d[31:0] = apply_strb(base_q[31:0], wdata_i, wstrb_i);
          else      err_o = 1'b1;
        end
        RegBaseHi: begin
          if (idle) base_d[AddrWidth-1:32] =
                      HiW'(apply_strb(32'(base_q[AddrWidth-1:32]), wdata_i, wstrb_i));
          else      err_o = 1'b1;
        end
        RegNumTask: begin
          if (idle) num_task_d = apply_strb(num_task_q, wdata_i, wstrb_i);
          else      err_o = 1'b1;
        end
        RegCtrl: begin
          if (start_req && !idle) err_o = 1'b1;
        end
        RegDoneCnt: done_cnt_d = '0;
        RegIrq: begin
          if (wstrb_i[0]) begin
            if (wdata_i[IrqPendingBit]) pending_d = 1'b0;
            enable_d = wdata_i[IrqEnableBit];
          end
        end
`ifdef QUAD_LAUNCH_TIMEOUT_EN
        RegTimeout: timeout_d = apply_strb(timeout_q, wdata_i, wstrb_i);
`endif
        default: ;
      endcase
    end

    // FSM runs after the register writes so hardware pending-set and the
    // DONE_CNT increment take precedence over a same-cycle W1C / clear.
    case (state_q)
      StIdle: begin
        if (start_req) begin
          if (num_task_q != '0) begin
            snap_base_d = base_q;
            snap_num_d  = num_task_q;
            err_d       = 1'b0;
            tmo_d       = 1'b0;
            state_d     = StReq;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StReq: begin
        if (launch_ready_i) begin
          state_d = StRun;
`ifdef QUAD_LAUNCH_TIMEOUT_EN
          tcnt_d  = '0;
`endif
        end
      end
      StRun: begin
        if (done_i) begin
          state_d   = StIdle;
          pending_d = 1'b1;
          if (done_cnt_d != '1) done_cnt_d = done_cnt_d + 32'd1;
        end else if (abort_req) begin
          state_d   = StIdle;
          pending_d = 1'b1;
          abort_d   = 1'b1;
        end
`ifdef QUAD_LAUNCH_TIMEOUT_EN
        // Fires on the cycle the count reaches TIMEOUT, so abort_o lands
        // exactly TIMEOUT cycles after entering RUN.
        else if ((timeout_q != '0) && ((tcnt_q + 32'd1) == timeout_q)) begin
          state_d   = StIdle;
          pending_d = 1'b1;
          abort_d   = 1'b1;
          tmo_d     = 1'b1;
        end else begin
          tcnt_d = tcnt_q + 32'd1;
        end
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      base_q      <= '0;
      num_task_q  <= '0;
      snap_base_q <= '0;
      snap_num_q  <= '0;
      done_cnt_q  <= '0;
      pending_q   <= 1'b0;
      enable_q    <= 1'b0;
      err_q       <= 1'b0;
      tmo_q       <= 1'b0;
      abort_q     <= 1'b0;
`ifdef QUAD_LAUNCH_TIMEOUT_EN
      timeout_q   <= '0;
      tcnt_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      num_task_q  <= num_task_d;
      snap_base_q <= snap_base_d;
      snap_num_q  <= snap_num_d;
      done_cnt_q  <= done_cnt_d;
      pending_q   <= pending_d;
      enable_q    <= enable_d;
      err_q       <= err_d;
      tmo_q       <= tmo_d;
      abort_q     <= abort_d;
`ifdef QUAD_LAUNCH_TIMEOUT_EN
      timeout_q   <= timeout_d;
      tcnt_q      <= tcnt_d;
`endif
    end
  end

  always_comb begin
    rdata_o = '0;
    case (off_i)
      RegBaseLo:  rdata_o = base_q[31:0];
      RegBaseHi:  rdata_o = 32'(base_q[AddrWidth-1:32]);
      RegNumTask: rdata_o = num_task_q;
      RegStatus: begin
        rdata_o[1:0]             = state_q;
        rdata_o[StatusErrBit]     = err_q;
        rdata_o[StatusTimeoutBit] = tmo_q;
      end
      RegDoneCnt: rdata_o = done_cnt_q;
      RegIrq: begin
        rdata_o[IrqPendingBit] = pending_q;
        rdata_o[IrqEnableBit]  = enable_q;
      end
`ifdef QUAD_LAUNCH_TIMEOUT_EN
      RegTimeout: rdata_o = timeout_q;
`endif
      default: rdata_o = '0;
    endcase
  end

  assign launch_valid_o     = (state_q == StReq);
  assign launch_base_addr_o = snap_base_q;
  assign launch_num_task_o  = snap_num_q;
  assign abort_o            = abort_q;
  assign busy_o             = !idle;
  assign irq_o              = pending_q & enable_q;

endmodule

// File: rtl/quad_bingo_launch_ctrl.sv
// rtl/quad_bingo_launch_ctrl.sv - multi-channel task-launch controller top
//
// Purpose: register-interface slave with address decoder and response mux,
// NumChannels launch channels, and the OR-reduced interrupt.
// Optional feature macro: QUAD_LAUNCH_TIMEOUT_EN (handled in the channel).
// Ports:
//   clk_i, rst_ni         clock, async active-low reset
//   reg_req_i, reg_rsp_o  register request / combinational response
//   launch_valid_o/ready  per-channel launch handshake
//   launch_base_addr_o    per-channel snapshotted base address
//   launch_num_task_o     per-channel snapshotted task count
//   done_i, abort_o       per-channel completion in / abort pulse out
//   busy_o                per-channel not-idle
//   irq_o                 OR of pending & enable over channels
module quad_bingo_launch_ctrl
  import quad_bingo_launch_pkg::*;
#(
  parameter int unsigned NumChannels = 2,
  parameter int unsigned AddrWidth   = 48,
  parameter type         reg_req_t   = reg_req_struct_t,
  parameter type         reg_rsp_t   = reg_rsp_struct_t
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  reg_req_t                              reg_req_i,
  output reg_rsp_t                              reg_rsp_o,
  output logic [NumChannels-1:0]                launch_valid_o,
  input  logic [NumChannels-1:0]                launch_ready_i,
  output logic [NumChannels-1:0][AddrWidth-1:0] launch_base_addr_o,
  output logic [NumChannels-1:0][31:0]          launch_num_task_o,
  input  logic [NumChannels-1:0]                done_i,
  output logic [NumChannels-1:0]                abort_o,
  output logic [NumChannels-1:0]                busy_o,
  output logic                                  irq_o
);

  // Block index = address / channel stride; INFO sits right after the last channel.
  logic [26:0] blk;
  logic        aligned, ch_hit, info_hit;
  logic [NumChannels-1:0]       ch_sel, ch_err, ch_irq;
  logic [NumChannels-1:0][31:0] ch_rdata;
  reg_rsp_t    rsp;

  assign blk      = reg_req_i.addr[31:5];
  assign aligned  = (reg_req_i.addr[1:0] == 2'b00);
  assign ch_hit   = aligned && (blk < 27'(NumChannels));
  assign info_hit = (blk == 27'(NumChannels)) && (reg_req_i.addr[4:0] == 5'h00);

  for (genvar i = 0; i < NumChannels; i++) begin : g_ch
    assign ch_sel[i] = reg_req_i.valid && ch_hit && (blk == 27'(i));

    quad_bingo_launch_channel #(
      .AddrWidth (AddrWidth)
    ) u_channel (
      .clk_i              (clk_i),
      .rst_ni             (rst_ni),
      .sel_i              (ch_sel[i]),
      .write_i            (reg_req_i.write),
      .off_i              ({reg_req_i.addr[4:2], 2'b00}),
      .wdata_i            (reg_req_i.wdata),
      .wstrb_i            (reg_req_i.wstrb),
      .rdata_o            (ch_rdata[i]),
      .err_o              (ch_err[i]),
      .launch_valid_o     (launch_valid_o[i]),
      .launch_ready_i     (launch_ready_i[i]),
      .launch_base_addr_o (launch_base_addr_o[i]),
      .launch_num_task_o  (launch_num_task_o[i]),
      .done_i             (done_i[i]),
      .abort_o            (abort_o[i]),
      .busy_o             (busy_o[i]),
      .irq_o              (ch_irq[i])
    );
  end

  always_comb begin
    rsp       = '0;
    rsp.ready = 1'b1;
    if (ch_hit) begin
      for (int i = 0; i < NumChannels; i++) begin
        if (blk == 27'(i)) begin
          rsp.rdata = ch_rdata[i];
          rsp.error = ch_err[i];
        end
      end
    end else if (info_hit) begin
      rsp.rdata = {16'h0000, 8'(AddrWidth), 8'(NumChannels)};
    end else begin
      rsp.error = reg_req_i.valid;
    end
  end

  assign reg_rsp_o = rsp;
  assign irq_o     = |ch_irq;

endmodule

// File: tb/tb_quad_bingo_launch_ctrl.sv
// tb/tb_quad_bingo_launch_ctrl.sv - directed scoreboard bench for quad_bingo_launch_ctrl
module tb_quad_bingo_launch_ctrl;
  import quad_bingo_launch_pkg::*;

  localparam int NC = 2;
  localparam int AW = 48;

  logic clk = 1'b0;
  logic rst_ni;
  always #5 clk = ~clk;

  reg_req_struct_t             req;
  reg_rsp_struct_t             rsp;
  logic [NC-1:0]               launch_valid, launch_ready, done, abort, busy;
  logic [NC-1:0][AW-1:0]       base;
  logic [NC-1:0][31:0]         num;
  logic                        irq;

  quad_bingo_launch_ctrl #(
    .NumChannels (NC),
    .AddrWidth   (AW)
  ) dut (
    .clk_i              (clk),
    .rst_ni             (rst_ni),
    .reg_req_i          (req),
    .reg_rsp_o          (rsp),
    .launch_valid_o     (launch_valid),
    .launch_ready_i     (launch_ready),
    .launch_base_addr_o (base),
    .launch_num_task_o  (num),
    .done_i             (done),
    .abort_o            (abort),
    .busy_o             (busy),
    .irq_o              (irq)
  );

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic        chk_data;
    string       tag;
  } exp_t;
  exp_t exp_q[$];

  logic [31:0] rd_data;
  logic        rd_err;

  function automatic logic [31:0] A(input int ch, input int off);
    return 32'(ch * 32 + off);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; response sampled mid-cycle, access commits at next posedge.
  task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    req.valid = 1'b1;
    req.write = w;
    req.addr  = a;
    req.wdata = d;
    req.wstrb = s;
    #3;
    rd_data = rsp.rdata;
    rd_err  = rsp.error;
    @(posedge clk);
    #1;
    req.valid = 1'b0;
    req.write = 1'b0;
  endtask

  task automatic compare_pop();
    exp_t x;
    x = exp_q.pop_front();
    check({x.tag, "_err"}, 64'(rd_err), 64'(x.err));
    if (x.chk_data) check(x.tag, 64'(rd_data), 64'(x.data));
  endtask

  task automatic expect_rd(input string tag, input logic [31:0] a, input logic [31:0] d, input logic e);
    exp_q.push_back('{data: d, err: e, chk_data: 1'b1, tag: tag});
    bus(1'b0, a, 32'h0, 4'h0);
    compare_pop();
  endtask

  task automatic expect_wr(input string tag, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic e);
    exp_q.push_back('{data: 32'h0, err: e, chk_data: 1'b0, tag: tag});
    bus(1'b1, a, d, s);
    compare_pop();
  endtask

  task automatic handshake(input int ch);
    launch_ready[ch] = 1'b1;
    tick();
    launch_ready[ch] = 1'b0;
  endtask

  initial begin
    req          = '0;
    launch_ready = '0;
    done         = '0;
    rst_ni       = 1'b0;
    repeat (2) tick();

    check("rst_valid", 64'(launch_valid), 0);
    check("rst_busy",  64'(busy), 0);
    check("rst_abort", 64'(abort), 0);
    check("rst_irq",   64'(irq), 0);
    check("rst_base0", 64'(base[0]), 0);
    check("rst_num1",  64'(num[1]), 0);

    rst_ni = 1'b1;
    tick();
    expect_rd("rst_status0", A(0, 'h10), 32'h0, 1'b0);
    expect_rd("rst_irq1",    A(1, 'h18), 32'h0, 1'b0);
    expect_rd("rst_cnt0",    A(0, 'h14), 32'h0, 1'b0);
    check("rsp_ready", 64'(rsp.ready), 1);
    expect_rd("info",     32'h40,  32'h0000_3002, 1'b0);
    expect_rd("unmapped", 32'h3FC, 32'h0, 1'b1);

    expect_wr("tmo_wr", A(0, 'h1C), 32'd7, 4'hF, 1'b0);
`ifdef QUAD_LAUNCH_TIMEOUT_EN
    expect_rd("tmo_rd", A(0, 'h1C), 32'd7, 1'b0);
    expect_wr("tmo_zero", A(0, 'h1C), 32'd0, 4'hF, 1'b0);
`else
    expect_rd("tmo_rd", A(0, 'h1C), 32'd0, 1'b0);
`endif

    // Launch on ch0 with strobed writes
    expect_wr("base_lo", A(0, 'h00), 32'h8000_0000, 4'hF, 1'b0);
    expect_wr("base_hi", A(0, 'h04), 32'hABCD_0012, 4'b0001, 1'b0);
    expect_rd("base_hi_rd", A(0, 'h04), 32'h12, 1'b0);
    expect_wr("num_wr", A(0, 'h08), 32'hFFFF_FF05, 4'b0001, 1'b0);
    expect_rd("num_rd", A(0, 'h08), 32'h5, 1'b0);
    check("valid_pre", 64'(launch_valid[0]), 0);
    expect_wr("start0", A(0, 'h0C), 32'h1, 4'h1, 1'b0);
    check("valid_t1", 64'(launch_valid[0]), 1);
    check("base_out", 64'(base[0]), 64'h12_8000_0000);
    check("num_out",  64'(num[0]), 5);
    expect_rd("status_req", A(0, 'h10), 32'h1, 1'b0);
    expect_wr("abort_in_req", A(0, 'h0C), 32'h2, 4'h1, 1'b0);
    check("abort_req_ign", 64'(abort[0]), 0);
    expect_wr("num_busy", A(0, 'h08), 32'h9, 4'hF, 1'b1);
    check("valid_held", 64'(launch_valid[0]), 1);
    check("base_held",  64'(base[0]), 64'h12_8000_0000);
    expect_rd("num_unchanged", A(0, 'h08), 32'h5, 1'b0);
    handshake(0);
    check("valid_run", 64'(launch_valid[0]), 0);
    expect_rd("status_run", A(0, 'h10), 32'h2, 1'b0);
    expect_wr("start_in_run", A(0, 'h0C), 32'h1, 4'h1, 1'b1);
    done[0] = 1'b1;
    tick();
    done[0] = 1'b0;
    check("busy_done", 64'(busy[0]), 0);
    expect_rd("done_cnt1", A(0, 'h14), 32'h1, 1'b0);
    expect_rd("status_idle", A(0, 'h10), 32'h0, 1'b0);
    expect_rd("pend0", A(0, 'h18), 32'h1, 1'b0);
    check("irq_masked", 64'(irq), 0);

    // Abort in RUN
    expect_wr("w1c0", A(0, 'h18), 32'h1, 4'h1, 1'b0);
    expect_wr("start0b", A(0, 'h0C), 32'h3, 4'h1, 1'b0);
    handshake(0);
    expect_wr("abort_run", A(0, 'h0C), 32'h2, 4'h1, 1'b0);
    check("abort_pulse", 64'(abort[0]), 1);
    check("busy_abort",  64'(busy[0]), 0);
    tick();
    check("abort_one_cycle", 64'(abort[0]), 0);
    expect_rd("cnt_after_abort", A(0, 'h14), 32'h1, 1'b0);
    expect_rd("pend_abort", A(0, 'h18), 32'h1, 1'b0);

    // Start with NUM_TASK=0
    expect_wr("start_zero", A(1, 'h0C), 32'h1, 4'h1, 1'b0);
    check("zero_no_valid", 64'(launch_valid[1]), 0);
    expect_rd("zero_err", A(1, 'h10), 32'h4, 1'b0);

    // IRQ on ch1
    expect_wr("irq_en1", A(1, 'h18), 32'h2, 4'h1, 1'b0);
    expect_wr("num1", A(1, 'h08), 32'h3, 4'hF, 1'b0);
    expect_wr("start1", A(1, 'h0C), 32'h1, 4'h1, 1'b0);
    handshake(1);
    expect_rd("status_run1", A(1, 'h10), 32'h2, 1'b0);
    done[1] = 1'b1;
    tick();
    done[1] = 1'b0;
    check("irq_set", 64'(irq), 1);
    expect_wr("start1b", A(1, 'h0C), 32'h1, 4'h1, 1'b0);
    handshake(1);
    done[1] = 1'b1;
    expect_wr("w1c_vs_set", A(1, 'h18), 32'h3, 4'h1, 1'b0);
    done[1] = 1'b0;
    check("irq_set_wins", 64'(irq), 1);
    expect_rd("irq1_rd", A(1, 'h18), 32'h3, 1'b0);
    expect_wr("w1c1", A(1, 'h18), 32'h3, 4'h1, 1'b0);
    check("irq_cleared", 64'(irq), 0);
    expect_rd("cnt1", A(1, 'h14), 32'h2, 1'b0);
    expect_wr("start1c", A(1, 'h0C), 32'h1, 4'h1, 1'b0);
    handshake(1);
    done[1] = 1'b1;
    expect_wr("cnt_clr_inc", A(1, 'h14), 32'h0, 4'hF, 1'b0);
    done[1] = 1'b0;
    expect_rd("cnt_clr_inc_rd", A(1, 'h14), 32'h1, 1'b0);

`ifdef QUAD_LAUNCH_TIMEOUT_EN
    begin
      int n;
      bit seen;
      n    = 0;
      seen = 1'b0;
      expect_wr("tmo10", A(0, 'h1C), 32'd10, 4'hF, 1'b0);
      expect_wr("start_tmo", A(0, 'h0C), 32'h1, 4'h1, 1'b0);
      handshake(0);
      for (int i = 1; i <= 20 && !seen; i++) begin
        tick();
        if (abort[0]) begin
          seen = 1'b1;
          n    = i;
        end
      end
      check("tmo_cycles", 64'(n), 10);
      expect_rd("tmo_status", A(0, 'h10), 32'h8, 1'b0);
    end
`endif

    // Reset mid-run
    expect_wr("start_rst", A(0, 'h0C), 32'h1, 4'h1, 1'b0);
    handshake(0);
    check("busy_prerst", 64'(busy[0]), 1);
    rst_ni = 1'b0;
    #2;
    check("rst_run_busy",  64'(busy), 0);
    check("rst_run_valid", 64'(launch_valid), 0);
    check("rst_run_abort", 64'(abort), 0);
    tick();
    rst_ni = 1'b1;
    tick();
    check("rst_no_abort", 64'(abort), 0);
    expect_rd("rst_cnt_clear", A(0, 'h14), 32'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/quad_bingo_launch_ctrl.md
# quad_bingo_launch_ctrl

Multi-channel task-launch controller for the quadrant peripheral space; the successor to the single-channel bingo HW manager start register. It has a register-interface slave with its own decoder and NumChannels independent launch channels. Each channel latches a task-list base address and task count, then issues a valid/ready launch to its HW manager. It tracks the run until `done_i`, counts completions, and raises a maskable interrupt.

## Interface
- `NumChannels`, 2: launch channels, 1..8.
- `AddrWidth`, 48: task-list base address width, 33..64.
- `reg_req_t`, logic: register-interface request type.
- `reg_rsp_t`, logic: register-interface response type.
- `clk_i`  in  1  clock; single clock domain.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `reg_req_i`  in  reg_req_t  register request.
- `reg_rsp_o`  out  reg_rsp_t  register response.
- `launch_valid_o`  out  [NumChannels]  launch request per channel.
- `launch_ready_i`  in  [NumChannels]  HW manager accepts launch.
- `launch_base_addr_o`  out  [NumChannels][AddrWidth]  snapshotted base address.
- `launch_num_task_o`  out  [NumChannels][32]  snapshotted task count.
- `done_i`  in  [NumChannels]  single-cycle completion pulse.
- `abort_o`  out  [NumChannels]  single-cycle abort pulse.
- `busy_o`  out  [NumChannels]  channel not IDLE.
- `irq_o`  out  1  OR over channels of pending & enable.

## Operation
- Register map per channel at base ch*0x20:
  - 0x00 BASE_LO (rw).
  - 0x04 BASE_HI (rw, bits [AddrWidth-33:0]; others read 0).
  - 0x08 NUM_TASK (rw).
  - 0x0C CTRL (wo; bit0 start, bit1 abort).
  - 0x10 STATUS (ro; [1:0] state, bit2 err, bit3 timeout).
  - 0x14 DONE_CNT (ro; any write clears).
  - 0x18 IRQ (bit0 pending W1C, bit1 enable rw).
  - 0x1C TIMEOUT.
- Global register at NumChannels*0x20: INFO (ro; [7:0] NumChannels, [15:8] AddrWidth).
- Unmapped address gives error=1, rdata 0.
- Per-channel FSM IDLE(0) → REQ(1) → RUN(2) → IDLE:
  - IDLE + start, NUM_TASK≠0: snapshot BASE/NUM_TASK to launch outputs, clear err/timeout, go to REQ.
  - IDLE + start, NUM_TASK=0: set err, stay in IDLE, no launch.
  - REQ: `launch_valid_o`=1; outputs stay stable until `launch_ready_i`, then go to RUN. Abort is ignored in REQ.
  - RUN + `done_i`: go to IDLE, DONE_CNT+1 (saturating at 2^32-1), set pending.
  - RUN + abort: pulse `abort_o`, go to IDLE, set pending; no count.
  - `done_i` outside RUN is ignored.
- A start while not IDLE returns error=1 and has no effect. Writes to BASE/NUM_TASK while not IDLE return error=1 and are dropped.
- A CTRL write with both bits set is treated as start only.
- Simultaneous hardware pending-set and SW W1C: the set wins.
- Simultaneous DONE_CNT clear and increment: the result is 1.
- Byte strobes are honoured on rw registers; CTRL acts only if wstrb[0].

## Timing
- Register response is combinational: ready=1, rdata/error valid in the same cycle.
- Start write at cycle t gives `launch_valid_o`=1 at t+1.
- Handshake at t gives RUN and `launch_valid_o`=0 at t+1.
- `done_i` at t gives IDLE, count update, pending, and `irq_o` at t+1.
- `abort_o` is high for exactly one cycle, at t+1 after the abort write.
- Reset values:
  - All outputs 0 and all registers 0.
  - State IDLE.
  - IRQ enable 0.
- Reset mid-run returns to IDLE with no abort pulse.

## Configuration
- `QUAD_LAUNCH_TIMEOUT_EN` defined:
  - TIMEOUT (rw, 32 bit) is active, with a per-channel cycle counter cleared on entering RUN.
  - If TIMEOUT≠0 and the counter reaches TIMEOUT in RUN: pulse `abort_o`, set the timeout status bit and pending, go to IDLE.
- Undefined: TIMEOUT reads 0, writes are accepted and ignored, no counter logic exists.

## Structure
- Package `quad_bingo_launch_pkg` holds:
  - Register offsets and channel stride (0x20).
  - The state enum (IDLE/REQ/RUN).
  - CTRL/STATUS/IRQ bit positions.
- Sub-module `quad_bingo_launch_channel` holds the FSM, snapshot registers, DONE_CNT, pending/enable and the optional timeout counter.
- The top module holds the decoder, the response mux and the `irq_o` OR, and generates NumChannels channel instances.

## Test plan
- Launch: ch0 BASE_LO=0x8000_0000, BASE_HI=0x12, NUM_TASK=5, start; ready held low for 3 cycles → valid stays high with base 0x12_8000_0000 and count 5; RUN one cycle after ready; `done_i` → DONE_CNT=1, STATUS=0.
- IRQ: enable=1 on ch1, complete a run → `irq_o`=1; W1C in the same cycle as a second `done_i` → pending stays 1; a later W1C → `irq_o`=0.
- Error paths:
  - Start with NUM_TASK=0 → err=1, no valid.
  - Start while in RUN → error=1.
  - NUM_TASK write while busy → error=1, value unchanged.
  - Read of 0x3FC → error=1.
- Abort: abort in REQ → ignored; abort in RUN → `abort_o` one cycle, IDLE, DONE_CNT unchanged, pending=1.
- Timeout (macro on): TIMEOUT=10, no done → `abort_o` 10 cycles after entering RUN, timeout bit=1. Macro off → TIMEOUT reads 0.
- Reset: assert `rst_ni` low in RUN → busy=0, valid=0, DONE_CNT=0.
